// File: rtl/mult_issue_pkg.sv
// Shared constants and types for the RV32M multiply issue unit.
package mult_issue_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } op_sel_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10
  } state_e;

  typedef struct packed {
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
  } req_entry_t;

  function automatic logic f3_legal(input logic [2:0] f3);
    return (f3[2] == 1'b0);
  endfunction

  function automatic op_sel_e f3_to_op(input logic [2:0] f3);
    case (f3)
      F3_MUL:    return OP_MUL;
      F3_MULH:   return OP_MULH;
      F3_MULHSU: return OP_MULHSU;
      F3_MULHU:  return OP_MULHU;
      default:   return OP_MUL;
    endcase
  endfunction

endpackage

// File: rtl/mult_issue_unit_if.sv
// Request, multiplier and writeback signals of mult_issue_unit.
// slave: the issue unit's view; master: the surrounding pipeline/multiplier.
interface mult_issue_unit_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_rs1_i;
  logic [31:0] req_rs2_i;
  logic [4:0]  req_rd_i;

  logic        mul_valid_o;
  logic        mul_ready_i;
  logic [31:0] mul_a_o;
  logic [31:0] mul_b_o;
  logic [1:0]  mul_op_o;

  logic        mul_res_valid_i;
  logic [31:0] mul_res_i;
  logic        mul_res_ready_o;

  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        wb_err_o;

  modport slave (
    input  req_valid_i, req_funct3_i, req_rs1_i, req_rs2_i, req_rd_i,
    output req_ready_o,
    output mul_valid_o, mul_a_o, mul_b_o, mul_op_o,
    input  mul_ready_i,
    input  mul_res_valid_i, mul_res_i,
    output mul_res_ready_o,
    output wb_valid_o, wb_rd_o, wb_data_o, wb_err_o,
    input  wb_ready_i
  );

  modport master (
    output req_valid_i, req_funct3_i, req_rs1_i, req_rs2_i, req_rd_i,
    input  req_ready_o,
    input  mul_valid_o, mul_a_o, mul_b_o, mul_op_o,
    output mul_ready_i,
    output mul_res_valid_i, mul_res_i,
    input  mul_res_ready_o,
    input  wb_valid_o, wb_rd_o, wb_data_o, wb_err_o,
    output wb_ready_i
  );
endinterface

// File: rtl/mult_issue_fifo.sv
// DEPTH-entry in-order request queue (DEPTH a power of two, >= 2).
module mult_issue_fifo
  import mult_issue_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_valid,
  output logic       push_ready,
  input  req_entry_t push_data,
  output logic       pop_valid,
  input  logic       pop_ready,
  output req_entry_t pop_data,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  req_entry_t  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        push_fire;
  logic        pop_fire;

  // Extra pointer bit separates full from empty when the indices match.
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty      = (wr_ptr == rd_ptr);
  assign push_ready = !full;
  assign pop_valid  = !empty;
  assign pop_data   = mem[rd_ptr[AW-1:0]];
  assign push_fire  = push_valid && push_ready;
  assign pop_fire   = pop_valid && pop_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_fire)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_fire) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mult_issue_unit.sv
// Queues RV32M multiply requests, issues them one at a time to an external
// multiplier and returns results in order. Option: MULT_ISSUE_ZERO_BYPASS_EN.
module mult_issue_unit
  import mult_issue_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input logic              clk,
  input logic              rst,
  mult_issue_unit_if.slave bus
);

`ifdef MULT_ISSUE_ZERO_BYPASS_EN
  localparam bit ZERO_BYPASS = 1'b1;
`else
  localparam bit ZERO_BYPASS = 1'b0;
`endif

  function automatic logic needs_mul(input req_entry_t e);
    return f3_legal(e.funct3) && !(ZERO_BYPASS && ((e.rs1 == '0) || (e.rs2 == '0)));
  endfunction

  state_e      state;
  state_e      state_nxt;
  req_entry_t  req_entry;
  req_entry_t  head;
  logic        head_valid;
  logic        fifo_push_ready;
  logic        fifo_full;
  logic        fifo_empty;
  logic        req_fire;
  logic        pop;
  logic        bypass_fire;
  logic        res_fire;
  logic        wb_fire;
  logic [4:0]  rd_q;
  logic        res_valid;
  logic        res_err;
  logic [4:0]  res_rd;
  logic [31:0] res_data;

  assign req_entry = '{funct3: bus.req_funct3_i, rs1: bus.req_rs1_i,
                       rs2: bus.req_rs2_i, rd: bus.req_rd_i};
  assign req_fire        = bus.req_valid_i && fifo_push_ready;
  assign bus.req_ready_o = !fifo_full;

  mult_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (bus.req_valid_i),
    .push_ready (fifo_push_ready),
    .push_data  (req_entry),
    .pop_valid  (head_valid),
    .pop_ready  (pop),
    .pop_data   (head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (!res_valid) begin
          if (head_valid) begin
            if (needs_mul(head)) state_nxt = S_ISSUE;
          // Empty queue: the request being accepted becomes the head next
          // cycle, so moving now gives single-cycle accept-to-issue.
          end else if (fifo_empty && req_fire && needs_mul(req_entry)) begin
            state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: if (bus.mul_ready_i) state_nxt = S_WAIT;
      S_WAIT:  if (bus.mul_res_valid_i && !res_valid) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.mul_valid_o     = 1'b0;
    bus.mul_a_o         = '0;
    bus.mul_b_o         = '0;
    bus.mul_op_o        = '0;
    bus.mul_res_ready_o = 1'b0;
    pop                 = 1'b0;
    bypass_fire         = 1'b0;
    case (state)
      S_IDLE: begin
        if (head_valid && !res_valid && !needs_mul(head)) begin
          pop         = 1'b1;
          bypass_fire = 1'b1;
        end
      end
      S_ISSUE: begin
        bus.mul_valid_o = 1'b1;
        bus.mul_a_o     = head.rs1;
        bus.mul_b_o     = head.rs2;
        bus.mul_op_o    = f3_to_op(head.funct3);
        pop             = bus.mul_ready_i;
      end
      S_WAIT:  bus.mul_res_ready_o = !res_valid;
      default: ;
    endcase
  end

  assign res_fire = bus.mul_res_valid_i && bus.mul_res_ready_o;
  assign wb_fire  = res_valid && bus.wb_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q      <= '0;
      res_valid <= 1'b0;
      res_err   <= 1'b0;
      res_rd    <= '0;
      res_data  <= '0;
    end else begin
      if ((state == S_ISSUE) && bus.mul_ready_i) rd_q <= head.rd;
      if (bypass_fire) begin
        res_valid <= 1'b1;
        res_rd    <= head.rd;
        res_data  <= '0;
        res_err   <= !f3_legal(head.funct3);
      end else if (res_fire) begin
        res_valid <= 1'b1;
        res_rd    <= rd_q;
        res_data  <= bus.mul_res_i;
        res_err   <= 1'b0;
      end else if (wb_fire) begin
        res_valid <= 1'b0;
        res_rd    <= '0;
        res_data  <= '0;
        res_err   <= 1'b0;
      end
    end
  end

  assign bus.wb_valid_o = res_valid;
  assign bus.wb_rd_o    = res_rd;
  assign bus.wb_data_o  = res_data;
  assign bus.wb_err_o   = res_err;

endmodule

// File: tb/tb_mult_issue_unit.sv
// Scoreboard bench for mult_issue_unit with a behavioural multiplier model.
// Zero-operand expectations follow MULT_ISSUE_ZERO_BYPASS_EN.
`timescale 1ns/1ps
module tb_mult_issue_unit;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
  } wb_exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_issue_unit_if bus();

  mult_issue_unit #(.DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int      tests = 0;
  int      fails = 0;
  wb_exp_t exp_q[$];
  bit      mul_stall = 1'b0;
  bit      mul_res_hold = 1'b0;
  bit      model_clear = 1'b0;
  int      res_delay = 0;
  int      mul_issue_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
    logic [63:0] sa, ua, sbx, ubx, p;
    sa  = {{32{a[31]}}, a};
    ua  = {32'b0, a};
    sbx = {{32{b[31]}}, b};
    ubx = {32'b0, b};
    case (op)
      2'b01:   p = sa * sbx;
      2'b10:   p = sa * ubx;
      default: p = ua * ubx;
    endcase
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Multiplier model: accepts an op, answers after res_delay cycles.
  initial begin : mul_model
    bit          op_fire, res_fire, pending;
    logic [31:0] pend_data;
    int          delay;
    pending = 1'b0;
    delay = 0;
    pend_data = '0;
    bus.mul_ready_i = 1'b0;
    bus.mul_res_valid_i = 1'b0;
    bus.mul_res_i = '0;
    forever begin
      @(negedge clk);
      op_fire  = bus.mul_valid_o && bus.mul_ready_i;
      res_fire = bus.mul_res_valid_i && bus.mul_res_ready_o;
      if (op_fire) begin
        mul_issue_count++;
        pend_data = ref_mul(bus.mul_a_o, bus.mul_b_o, bus.mul_op_o);
      end
      @(posedge clk);
      #1;
      if (res_fire) begin
        pending = 1'b0;
        bus.mul_res_valid_i = 1'b0;
      end
      if (op_fire) begin
        pending = 1'b1;
        delay = res_delay;
      end
      if (pending && !bus.mul_res_valid_i && !mul_res_hold) begin
        if (delay == 0) begin
          bus.mul_res_valid_i = 1'b1;
          bus.mul_res_i = pend_data;
        end else begin
          delay--;
        end
      end
      if (model_clear) begin
        pending = 1'b0;
        bus.mul_res_valid_i = 1'b0;
        model_clear = 1'b0;
      end
      bus.mul_ready_i = !mul_stall;
    end
  end

  // Writeback monitor: scoreboard pop on handshake, stability while stalled.
  initial begin : monitor
    wb_exp_t     e;
    logic        snap_valid;
    logic [37:0] snap;
    snap_valid = 1'b0;
    snap = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        snap_valid = 1'b0;
        continue;
      end
      if (snap_valid) begin
        tests++;
        if (!bus.wb_valid_o || ({bus.wb_rd_o, bus.wb_data_o, bus.wb_err_o} !== snap)) begin
          fails++;
          $display("FAIL wb_hold: actual valid=%b rd=%0d data=%h err=%b expected valid=1 rd=%0d data=%h err=%b",
                   bus.wb_valid_o, bus.wb_rd_o, bus.wb_data_o, bus.wb_err_o,
                   snap[37:33], snap[32:1], snap[0]);
        end
      end
      snap_valid = bus.wb_valid_o && !bus.wb_ready_i;
      snap = {bus.wb_rd_o, bus.wb_data_o, bus.wb_err_o};
      if (bus.wb_valid_o && bus.wb_ready_i) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL wb_unexpected: actual rd=%0d data=%h err=%b expected no writeback",
                   bus.wb_rd_o, bus.wb_data_o, bus.wb_err_o);
        end else begin
          e = exp_q.pop_front();
          if ({bus.wb_rd_o, bus.wb_data_o, bus.wb_err_o} !== {e.rd, e.data, e.err}) begin
            fails++;
            $display("FAIL wb_data: actual rd=%0d data=%h err=%b expected rd=%0d data=%h err=%b",
                     bus.wb_rd_o, bus.wb_data_o, bus.wb_err_o, e.rd, e.data, e.err);
          end
        end
      end
    end
  end

  task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input logic [31:0] exp_data, input logic exp_err);
    bit done;
    done = 1'b0;
    bus.req_valid_i  = 1'b1;
    bus.req_funct3_i = f3;
    bus.req_rs1_i    = a;
    bus.req_rs2_i    = b;
    bus.req_rd_i     = rd;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (bus.req_ready_o) begin
        exp_q.push_back('{rd: rd, data: exp_data, err: exp_err});
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    bus.req_valid_i = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: actual req_ready=0 for 200 cycles expected 1 (rd=%0d)", rd);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.wb_valid_o) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_checks(input string name);
    chk({name, "_req_ready"},     32'(bus.req_ready_o),     32'd1);
    chk({name, "_mul_valid"},     32'(bus.mul_valid_o),     32'd0);
    chk({name, "_mul_res_ready"}, 32'(bus.mul_res_ready_o), 32'd0);
    chk({name, "_wb_valid"},      32'(bus.wb_valid_o),      32'd0);
    chk({name, "_wb_err"},        32'(bus.wb_err_o),        32'd0);
    chk({name, "_mul_a"},         bus.mul_a_o,              32'd0);
    chk({name, "_mul_b"},         bus.mul_b_o,              32'd0);
    chk({name, "_mul_op"},        32'(bus.mul_op_o),        32'd0);
    chk({name, "_wb_rd"},         32'(bus.wb_rd_o),         32'd0);
    chk({name, "_wb_data"},       bus.wb_data_o,            32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: actual simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bit seen;
    int c0;
    bus.req_valid_i  = 1'b0;
    bus.req_funct3_i = '0;
    bus.req_rs1_i    = '0;
    bus.req_rs2_i    = '0;
    bus.req_rd_i     = '0;
    bus.wb_ready_i   = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    reset_checks("reset");
    @(posedge clk);
    #1;

    // MUL with one-cycle issue and writeback latency
    send(3'b000, 32'd3, 32'hFFFF_FFFE, 5'd5, 32'hFFFF_FFFA, 1'b0);
    @(negedge clk);
    chk("issue_latency", 32'(bus.mul_valid_o), 32'd1);
    chk("mul_a",  bus.mul_a_o, 32'd3);
    chk("mul_b",  bus.mul_b_o, 32'hFFFF_FFFE);
    chk("mul_op", 32'(bus.mul_op_o), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (bus.mul_res_valid_i && bus.mul_res_ready_o) seen = 1'b1;
      else @(negedge clk);
    end
    chk("res_handshake", 32'(seen), 32'd1);
    if (seen) begin
      @(negedge clk);
      chk("wb_latency", 32'(bus.wb_valid_o), 32'd1);
    end
    @(posedge clk);
    #1;
    drain("mul");

    // high-half variants
    send(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE, 1'b0);
    @(negedge clk);
    chk("mulhu_op", 32'(bus.mul_op_o), 32'd3);
    @(posedge clk);
    #1;
    drain("mulhu");
    res_delay = 2;
    send(3'b001, 32'd2, 32'h8000_0000, 5'd7, 32'hFFFF_FFFF, 1'b0);
    send(3'b010, 32'd2, 32'h8000_0000, 5'd8, 32'h0000_0001, 1'b0);
    drain("mulh_mulhsu");
    res_delay = 0;

    // queue full while the multiplier stalls
    mul_stall = 1'b1;
    @(posedge clk);
    #1;
    send(3'b000, 32'd2, 32'd3, 5'd1, 32'd6, 1'b0);
    send(3'b000, 32'd4, 32'd5, 5'd2, 32'd20, 1'b0);
    bus.req_valid_i  = 1'b1;
    bus.req_funct3_i = 3'b000;
    bus.req_rs1_i    = 32'd7;
    bus.req_rs2_i    = 32'd8;
    bus.req_rd_i     = 5'd3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("full_stall", 32'(bus.req_ready_o), 32'd0);
      @(posedge clk);
      #1;
    end
    mul_stall = 1'b0;
    send(3'b000, 32'd7, 32'd8, 5'd3, 32'd56, 1'b0);
    drain("backpressure");

    // illegal funct3 between legal ops
    c0 = mul_issue_count;
    send(3'b000, 32'd5, 32'd6, 5'd7, 32'd30, 1'b0);
    send(3'b100, 32'd9, 32'd9, 5'd8, 32'd0, 1'b1);
    send(3'b000, 32'd10, 32'd10, 5'd9, 32'd100, 1'b0);
    send(3'b111, 32'd1, 32'd1, 5'd15, 32'd0, 1'b1);
    drain("illegal");
    chk("illegal_not_issued", 32'(mul_issue_count - c0), 32'd2);

    // writeback stall holds outputs and blocks result capture
    bus.wb_ready_i = 1'b0;
    send(3'b000, 32'd6, 32'd7, 5'd10, 32'd42, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus.wb_valid_o) seen = 1'b1;
    end
    chk("wb_rise", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
    send(3'b000, 32'd2, 32'd2, 5'd11, 32'd4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid",     32'(bus.wb_valid_o),      32'd1);
      chk("hold_data",      bus.wb_data_o,            32'd42);
      chk("hold_rd",        32'(bus.wb_rd_o),         32'd10);
      chk("hold_res_ready", 32'(bus.mul_res_ready_o), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.wb_ready_i = 1'b1;
    drain("wb_stall");

    // rd = 0 still executes
    send(3'b000, 32'd4, 32'd4, 5'd0, 32'd16, 1'b0);
    drain("rd0");

    // reset while waiting on the multiplier, then a stray result
    mul_res_hold = 1'b1;
    @(posedge clk);
    #1;
    send(3'b000, 32'd3, 32'd3, 5'd12, 32'd9, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus.mul_res_ready_o) seen = 1'b1;
    end
    chk("wait_reached", 32'(seen), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    mul_res_hold = 1'b0;
    @(negedge clk);
    reset_checks("midrst");
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("stray_wb_valid",  32'(bus.wb_valid_o),      32'd0);
      chk("stray_req_ready", 32'(bus.req_ready_o),     32'd1);
      chk("stray_res_ready", 32'(bus.mul_res_ready_o), 32'd0);
    end
    model_clear = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // zero operands
    c0 = mul_issue_count;
    send(3'b000, 32'd0, 32'd123, 5'd13, 32'd0, 1'b0);
    send(3'b011, 32'd5, 32'd0, 5'd14, 32'd0, 1'b0);
    drain("zero_op");
`ifdef MULT_ISSUE_ZERO_BYPASS_EN
    chk("zero_issue_count", 32'(mul_issue_count - c0), 32'd0);
`else
    chk("zero_issue_count", 32'(mul_issue_count - c0), 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mult_issue_unit.md
MULT_ISSUE_UNIT -- requirements
Module: mult_issue_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 2, request-queue entries (power of two, >=2).
REQ-002 SHALL have clock and reset as decided: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 req_valid_i / req_ready_o  in/out  1/1  upstream (execute) request handshake.
REQ-006 req_funct3_i  input  3  RV32M funct3; req_rs1_i, req_rs2_i  input  32  operands; req_rd_i  input  5  destination.
REQ-007 mul_valid_o / mul_ready_i  out/in  1/1  multiplier input handshake; mul_a_o, mul_b_o  output  32; mul_op_o  output  2.
REQ-008 mul_res_valid_i  input  1, mul_res_i  input  32, mul_res_ready_o  output  1  multiplier result side.
REQ-009 wb_valid_o / wb_ready_i  out/in  1/1; wb_rd_o  output  5; wb_data_o  output  32; wb_err_o  output  1  writeback side.

Function
REQ-010 Request SHALL be accepted when req_valid_i && req_ready_o; req_ready_o = queue not full.
REQ-011 Queue SHALL be FIFO, in-order; simultaneous push and pop when full SHALL NOT be accepted (req_ready_o low when full).
REQ-012 funct3 map SHALL be 000->op 00 (MUL), 001->01 (MULH), 010->10 (MULHSU), 011->11 (MULHU).
REQ-013 funct3[2]=1 SHALL be illegal: never sent to multiplier; produces writeback with wb_err_o=1, wb_data_o=0.
REQ-014 FSM states SHALL be IDLE, ISSUE, WAIT.
REQ-015 IDLE: head entry present, result register empty -> legal op to ISSUE; illegal/bypass entry written to result register directly, popped, stays IDLE.
REQ-016 ISSUE: mul_valid_o=1 with head operands/op; on mul_ready_i pop head, latch rd, -> WAIT.
REQ-017 WAIT: mul_res_ready_o=1 only in WAIT with result register empty; on mul_res_valid_i capture mul_res_i and rd, -> IDLE.
REQ-018 mul_res_ready_o SHALL be 0 in IDLE and ISSUE; at most one multiplier operation in flight.
REQ-019 wb_valid_o SHALL rise the cycle after result capture; outputs held stable until wb_ready_i; register cleared on wb_valid_o && wb_ready_i.
REQ-020 Minimum latency: accept at cycle N -> mul_valid_o at N+1; mul_res_valid_i at M -> wb_valid_o at M+1.
REQ-021 Writeback order SHALL equal acceptance order, including illegal and bypass entries.
REQ-022 rd=0 SHALL still be executed and written back unchanged.

Reset
REQ-023 On rst: queue empty, FSM IDLE, result register empty; req_ready_o=1 next cycle; mul_valid_o, mul_res_ready_o, wb_valid_o, wb_err_o = 0; mul_a_o, mul_b_o, mul_op_o, wb_rd_o, wb_data_o = 0.
REQ-024 Reset mid-operation SHALL discard all queued and in-flight entries; a later mul_res_valid_i with FSM in IDLE SHALL be ignored.

Configuration
REQ-025 Macro MULT_ISSUE_ZERO_BYPASS_EN defined: legal entry with rs1=0 or rs2=0 SHALL complete in IDLE with wb_data_o=0, skipping the multiplier.
REQ-026 Macro undefined: every legal entry SHALL go through ISSUE/WAIT.

Structure
REQ-027 Package mult_issue_pkg SHALL hold funct3 constants, op_sel enum, FSM state enum, and the queue-entry struct (funct3, rs1, rs2, rd).
REQ-028 Queue SHALL be sub-module mult_issue_fifo (DEPTH-parametric, valid/ready push and pop, full/empty flags).

Verification
REQ-029 MUL rs1=3, rs2=0xFFFFFFFE, rd=5, multiplier model returns low product -> wb_data_o=0xFFFFFFFA, wb_rd_o=5, wb_err_o=0.
REQ-030 MULHU rs1=rs2=0xFFFFFFFF -> mul_op_o=11, wb_data_o=0xFFFFFFFE.
REQ-031 DEPTH=2, mul_ready_i held 0, three back-to-back requests -> third stalls (req_ready_o=0 once queue full), all three later written back in order.
REQ-032 funct3=100 between two MULs -> no mul_valid_o for it, middle writeback wb_err_o=1, data 0, order preserved.
REQ-033 wb_ready_i held 0 for 5 cycles after wb_valid_o -> wb outputs stable, mul_res_ready_o=0 while result register full.
REQ-034 rst asserted during WAIT, then stray mul_res_valid_i -> no wb_valid_o, req_ready_o=1; with MULT_ISSUE_ZERO_BYPASS_EN, MUL rs1=0 -> wb_data_o=0 with no mul_valid_o.
